// File: rtl/data_map_pkg.sv
// Shared constants and types for the pixel pack/unpack datapaths.
// Holds the unpacker FSM states and the helpers that size the bit buffer
// and its fill counter from the narrow/wide widths.
package data_map_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int DEF_ISIZE = 24;
    localparam int DEF_OSIZE = 256;
    localparam int DEF_LW    = 16;

    // Bit buffer holds one full word plus up to ISIZE-1 leftover bits.
    function automatic int buf_width(input int isize, input int osize);
        return osize + isize - 1;
    endfunction

    // Fill counter must reach OSIZE+ISIZE-1.
    function automatic int cnt_width(input int isize, input int osize);
        return $clog2(osize + isize);
    endfunction

    localparam int CW = cnt_width(DEF_ISIZE, DEF_OSIZE);
    localparam int BW = buf_width(DEF_ISIZE, DEF_OSIZE);

endpackage

// File: rtl/split_data.sv
// split_data: unpacks wide read words into a narrow MSB-first pixel stream.
// Pixels may straddle words; bits after a line's last pixel are padding and
// are dropped. A sticky err flags lines whose ilast word disagrees with
// line_pixels; the DRAIN state swallows words until the late ilast word.
module split_data
    import data_map_pkg::*;
#(
    parameter int ISIZE = DEF_ISIZE,
    parameter int OSIZE = DEF_OSIZE,
    parameter int LW    = DEF_LW
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             ialign,
    input  logic [LW-1:0]    line_pixels,
    input  logic             ivalid,
    output logic             iready,
    input  logic [OSIZE-1:0] idata,
    input  logic             ilast,
    output logic             ovalid,
    input  logic             oready,
    output logic [ISIZE-1:0] odata,
    output logic             olast,
    output logic             err
);

    localparam int CNT_W = cnt_width(ISIZE, OSIZE);
    localparam int BUF_W = buf_width(ISIZE, OSIZE);
    localparam logic [CNT_W-1:0] ISZ_C  = CNT_W'(ISIZE);
    localparam logic [CNT_W-1:0] OSZ_C  = CNT_W'(OSIZE);
    localparam logic [LW-1:0]    ONE_LW = {{(LW-1){1'b0}}, 1'b1};

    // registered state
    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BUF_W-1:0]   buf_r;
    logic [LW-1:0]      pix_cnt_r;
    logic [LW-1:0]      lp_r;
    logic               lastw_r;
    logic               err_r;
    logic               en_r;

    // next-state values
    state_t             state_n_s;
    logic [CNT_W-1:0]   cnt_n_s;
    logic [BUF_W-1:0]   buf_n_s;
    logic [LW-1:0]      pix_n_s;
    logic [LW-1:0]      lp_n_s;
    logic               lastw_n_s;
    logic               err_n_s;

    // handshake and datapath helpers
    logic               ovalid_s;
    logic               olast_s;
    logic               pop_s;
    logic               push_s;
    logic               iready_s;
    logic               line_end_s;
    logic               early_s;
    logic               idle_s;
    logic [CNT_W-1:0]   rem_s;
    logic [CNT_W-1:0]   ins_at_s;
    logic [BUF_W-1:0]   shifted_s;
    logic [BUF_W-1:0]   word_s;
    logic [BUF_W-1:0]   keep_s;
    logic [BUF_W-1:0]   ins_buf_s;
    logic [LW-1:0]      lp_in_s;

    // Output/handshake decode: pixel availability, pops and word acceptance.
    always_comb begin
        ovalid_s   = (state_r == ST_RUN) && (cnt_r >= ISZ_C) && !ialign;
        olast_s    = ovalid_s && (pix_cnt_r == (lp_r - ONE_LW));
        pop_s      = ovalid_s && oready;
        line_end_s = pop_s && olast_s;
        if (pop_s) begin
            rem_s = cnt_r - ISZ_C;
        end else begin
            rem_s = cnt_r;
        end
        if (!en_r || ialign) begin
            iready_s = 1'b0;
        end else if (state_r == ST_DRAIN) begin
            iready_s = 1'b1;
        end else begin
            // a line end drops the residue, so room always exists then
            iready_s = (rem_s < ISZ_C) || line_end_s;
        end
        push_s  = ivalid && iready_s;
        // ilast word already in, not enough bits left, no last pixel yet
        early_s = (state_r == ST_RUN) && lastw_r && (rem_s < ISZ_C) &&
                  !line_end_s && !ialign;
        idle_s  = (cnt_r == {CNT_W{1'b0}}) && (pix_cnt_r == {LW{1'b0}});
    end

    // Datapath: shift out the popped pixel and splice an incoming word below the residue.
    always_comb begin
        if (line_end_s || early_s) begin
            ins_at_s = {CNT_W{1'b0}};
        end else begin
            ins_at_s = rem_s;
        end
        if (pop_s) begin
            shifted_s = buf_r << ISIZE;
        end else begin
            shifted_s = buf_r;
        end
        word_s    = {idata, {(ISIZE-1){1'b0}}} >> ins_at_s;
        keep_s    = ~({BUF_W{1'b1}} >> ins_at_s);
        ins_buf_s = (shifted_s & keep_s) | word_s;
        if (line_pixels == {LW{1'b0}}) begin
            lp_in_s = ONE_LW;
        end else begin
            lp_in_s = line_pixels;
        end
    end

    // Next-state logic: FSM transitions plus buffer, counters and error flag.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        buf_n_s   = buf_r;
        pix_n_s   = pix_cnt_r;
        lastw_n_s = lastw_r;
        err_n_s   = err_r;
        lp_n_s    = lp_r;
        if (ialign) begin
            state_n_s = ST_RUN;
            cnt_n_s   = {CNT_W{1'b0}};
            pix_n_s   = {LW{1'b0}};
            lastw_n_s = 1'b0;
            err_n_s   = 1'b0;
        end else if (state_r == ST_DRAIN) begin
            if (push_s && ilast) begin
                state_n_s = ST_RUN;
            end else begin
                state_n_s = ST_DRAIN;
            end
        end else if (line_end_s) begin
            pix_n_s   = {LW{1'b0}};
            lastw_n_s = 1'b0;
            cnt_n_s   = {CNT_W{1'b0}};
            buf_n_s   = shifted_s;
            if (!lastw_r) begin
                // ilast word not seen yet: anything pushed now is still this line's
                err_n_s = 1'b1;
                if (push_s && ilast) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end else if (push_s) begin
                buf_n_s   = ins_buf_s;
                cnt_n_s   = OSZ_C;
                lastw_n_s = ilast;
                lp_n_s    = lp_in_s;
            end else begin
                state_n_s = ST_RUN;
            end
        end else if (early_s) begin
            err_n_s   = 1'b1;
            pix_n_s   = {LW{1'b0}};
            lastw_n_s = 1'b0;
            buf_n_s   = shifted_s;
            if (push_s) begin
                buf_n_s   = ins_buf_s;
                cnt_n_s   = OSZ_C;
                lastw_n_s = ilast;
                lp_n_s    = lp_in_s;
            end else begin
                cnt_n_s = {CNT_W{1'b0}};
            end
        end else begin
            if (pop_s) begin
                pix_n_s = pix_cnt_r + ONE_LW;
            end else begin
                pix_n_s = pix_cnt_r;
            end
            if (push_s) begin
                buf_n_s   = ins_buf_s;
                cnt_n_s   = rem_s + OSZ_C;
                lastw_n_s = ilast;
                if (idle_s) begin
                    lp_n_s = lp_in_s;
                end else begin
                    lp_n_s = lp_r;
                end
            end else begin
                buf_n_s = shifted_s;
                cnt_n_s = rem_s;
            end
        end
    end

    // State register: async reset clears everything; iready opens one edge after release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            cnt_r     <= {CNT_W{1'b0}};
            buf_r     <= {BUF_W{1'b0}};
            pix_cnt_r <= {LW{1'b0}};
            lp_r      <= ONE_LW;
            lastw_r   <= 1'b0;
            err_r     <= 1'b0;
            en_r      <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            cnt_r     <= cnt_n_s;
            buf_r     <= buf_n_s;
            pix_cnt_r <= pix_n_s;
            lp_r      <= lp_n_s;
            lastw_r   <= lastw_n_s;
            err_r     <= err_n_s;
            en_r      <= 1'b1;
        end
    end

    assign iready = iready_s;
    assign ovalid = ovalid_s;
    assign olast  = olast_s;
    assign odata  = buf_r[BUF_W-1 -: ISIZE];
    assign err    = err_r;

endmodule
